// File: rtl/vram_pkg.sv
// Shared types and constants for the text VRAM arbiter.
// Optional posted-write buffer is enabled by defining VRAM_ARB_WRBUF_EN.
package vram_pkg;

   localparam int VRAM_AW          = 12;
   localparam int MAX_WAIT_DEFAULT = 15;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_PEND = 2'd1,
      ST_CAPT = 2'd2,
      ST_DONE = 2'd3
   } cpu_state_e;

   // Counter width able to hold max_wait without wrapping (at least one bit).
   function automatic int wait_width(input int max_wait);
      return (max_wait < 2) ? 1 : $clog2(max_wait + 1);
   endfunction

endpackage

// File: rtl/vram_wait_timer.sv
// Saturating count of cycles a CPU-side access has been blocked by the display.
// expired is never asserted when MAX_WAIT is 0 (forced grants disabled).
module vram_wait_timer
   import vram_pkg::*;
#(
   parameter int MAX_WAIT = MAX_WAIT_DEFAULT
) (
   input  logic clock,
   input  logic reset,
   input  logic clear,
   input  logic count,
   output logic expired
);

   localparam int              W     = wait_width(MAX_WAIT);
   localparam logic [W-1:0]    LIMIT = W'(MAX_WAIT);

   logic [W-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (clear) begin
         count_d = '0;
      end else if (count && (count_q != LIMIT)) begin
         count_d = count_q + W'(1);
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign expired = (MAX_WAIT != 0) && (count_q == LIMIT);

endmodule

// File: rtl/vram_arbiter.sv
// Single-port text VRAM arbiter: display has priority, CPU uses free or forced slots.
// Define VRAM_ARB_WRBUF_EN to add a one-entry posted write buffer.
module vram_arbiter
   import vram_pkg::*;
#(
   parameter int AW       = VRAM_AW,
   parameter int MAX_WAIT = MAX_WAIT_DEFAULT
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          vid_req,
   input  logic [AW-1:0] vid_address,
   output logic [7:0]    vid_data,
   output logic          vid_stall,
   input  logic          cpu_req,
   input  logic          cpu_we,
   input  logic [AW-1:0] cpu_address,
   input  logic [7:0]    cpu_wdata,
   output logic [7:0]    cpu_rdata,
   output logic          cpu_ack,
   output logic [AW-1:0] mem_address,
   output logic          mem_wren,
   output logic [7:0]    mem_wdata,
   input  logic [7:0]    mem_rdata
);

   cpu_state_e    state_q, state_d;
   logic          req_we_q, req_we_d;
   logic [AW-1:0] req_addr_q, req_addr_d;
   logic [7:0]    req_wdata_q, req_wdata_d;
   logic [7:0]    rdata_q, rdata_d;
   logic          vid_stall_q, vid_stall_d;

   logic          expired;
   logic          slot_free;
   logic          issue_cpu;
   logic          issue_wb;
   logic          waiting;

   logic          wb_valid;
   logic [AW-1:0] wb_addr;
   logic [7:0]    wb_data;

`ifdef VRAM_ARB_WRBUF_EN
   logic          wb_valid_q, wb_valid_d;
   logic [AW-1:0] wb_addr_q, wb_addr_d;
   logic [7:0]    wb_data_q, wb_data_d;

   assign wb_valid = wb_valid_q;
   assign wb_addr  = wb_addr_q;
   assign wb_data  = wb_data_q;
`else
   assign wb_valid = 1'b0;
   assign wb_addr  = '0;
   assign wb_data  = '0;
`endif

   // A posted write drains before any queued CPU access is allowed to issue.
   assign slot_free = !vid_req || expired;
   assign issue_wb  = wb_valid && slot_free;
   assign issue_cpu = (state_q == ST_PEND) && slot_free && !wb_valid;
   assign waiting   = (state_q == ST_PEND) || wb_valid;

   vram_wait_timer #(
      .MAX_WAIT (MAX_WAIT)
   ) u_wait_timer (
      .clock   (clock),
      .reset   (reset),
      .clear   (!waiting || issue_cpu || issue_wb),
      .count   (waiting && vid_req),
      .expired (expired)
   );

   always_comb begin
      mem_address = vid_address;
      mem_wren    = 1'b0;
      mem_wdata   = req_wdata_q;
      if (issue_wb) begin
         mem_address = wb_addr;
         mem_wren    = 1'b1;
         mem_wdata   = wb_data;
      end else if (issue_cpu) begin
         mem_address = req_addr_q;
         mem_wren    = req_we_q;
      end
   end

   // NOTE: every signal driven here gets a default first, so no path can infer a latch.
   always_comb begin
      state_d     = state_q;
      req_we_d    = req_we_q;
      req_addr_d  = req_addr_q;
      req_wdata_d = req_wdata_q;
      rdata_d     = rdata_q;
      vid_stall_d = (issue_cpu || issue_wb) && vid_req;
`ifdef VRAM_ARB_WRBUF_EN
      wb_valid_d  = wb_valid_q && !issue_wb;
      wb_addr_d   = wb_addr_q;
      wb_data_d   = wb_data_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (cpu_req) begin
`ifdef VRAM_ARB_WRBUF_EN
               if (cpu_we && !wb_valid_q) begin
                  wb_valid_d = 1'b1;
                  wb_addr_d  = cpu_address;
                  wb_data_d  = cpu_wdata;
                  state_d    = ST_DONE;
               end else begin
                  req_we_d    = cpu_we;
                  req_addr_d  = cpu_address;
                  req_wdata_d = cpu_wdata;
                  state_d     = ST_PEND;
               end
`else
               req_we_d    = cpu_we;
               req_addr_d  = cpu_address;
               req_wdata_d = cpu_wdata;
               state_d     = ST_PEND;
`endif
            end
         end
         ST_PEND: begin
            if (issue_cpu) begin
               state_d = req_we_q ? ST_DONE : ST_CAPT;
            end
         end
         ST_CAPT: begin
            rdata_d = mem_rdata;
            state_d = ST_DONE;
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         req_we_q    <= 1'b0;
         req_addr_q  <= '0;
         req_wdata_q <= '0;
         rdata_q     <= '0;
         vid_stall_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         req_we_q    <= req_we_d;
         req_addr_q  <= req_addr_d;
         req_wdata_q <= req_wdata_d;
         rdata_q     <= rdata_d;
         vid_stall_q <= vid_stall_d;
      end
   end

`ifdef VRAM_ARB_WRBUF_EN
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wb_valid_q <= 1'b0;
         wb_addr_q  <= '0;
         wb_data_q  <= '0;
      end else begin
         wb_valid_q <= wb_valid_d;
         wb_addr_q  <= wb_addr_d;
         wb_data_q  <= wb_data_d;
      end
   end
`endif

   assign cpu_ack   = (state_q == ST_DONE);
   assign cpu_rdata = rdata_q;
   assign vid_data  = mem_rdata;
   assign vid_stall = vid_stall_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// Randomized bench for vram_arbiter against a cycle-count and shadow-memory reference.
// Honours VRAM_ARB_WRBUF_EN in the same way as the design.
module tb_vram_arbiter;
   import vram_pkg::*;

   localparam int AW = VRAM_AW;
   localparam int MW = MAX_WAIT_DEFAULT;

   logic          clock = 1'b0;
   logic          reset;
   logic          vid_req;
   logic [AW-1:0] vid_address;
   logic [7:0]    vid_data;
   logic          vid_stall;
   logic          cpu_req;
   logic          cpu_we;
   logic [AW-1:0] cpu_address;
   logic [7:0]    cpu_wdata;
   logic [7:0]    cpu_rdata;
   logic          cpu_ack;
   logic [AW-1:0] mem_address;
   logic          mem_wren;
   logic [7:0]    mem_wdata;
   logic [7:0]    mem_rdata;

   vram_arbiter #(
      .AW       (AW),
      .MAX_WAIT (MW)
   ) dut (
      .clock       (clock),
      .reset       (reset),
      .vid_req     (vid_req),
      .vid_address (vid_address),
      .vid_data    (vid_data),
      .vid_stall   (vid_stall),
      .cpu_req     (cpu_req),
      .cpu_we      (cpu_we),
      .cpu_address (cpu_address),
      .cpu_wdata   (cpu_wdata),
      .cpu_rdata   (cpu_rdata),
      .cpu_ack     (cpu_ack),
      .mem_address (mem_address),
      .mem_wren    (mem_wren),
      .mem_wdata   (mem_wdata),
      .mem_rdata   (mem_rdata)
   );

   always #5 clock = ~clock;

   // Bare synchronous RAM the arbiter drives; ref_mem is the expected contents.
   logic [7:0] ram     [0:(1<<AW)-1];
   logic [7:0] ref_mem [0:(1<<AW)-1];

   always @(posedge clock) begin
      if (mem_wren) ram[mem_address] <= mem_wdata;
      mem_rdata <= ram[mem_address];
   end

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", tag, got, got, exp, exp, $time);
      end
   endtask

   task automatic next_cycle();
      @(posedge clock);
      #1;
   endtask

   // One CPU transaction; vid_req is held high for cycles 0..busy-1 counted from the request.
   task automatic do_txn(input bit we, input logic [AW-1:0] addr, input logic [7:0] wd, input int busy);
      int         cyc       = 0;
      int         ack_cyc   = -1;
      int         stall_cyc = -1;
      int         wren_cnt  = 0;
      logic [7:0] rd        = 8'h00;
      int         blocked;
      int         exp_ack;
      int         exp_stall;
      bit         forced    = 1'b0;
      bit         buffered  = 1'b0;

      // Request seen in cycle 0, pending from cycle 1; each busy pending cycle blocks once.
      blocked = (busy > 1) ? busy - 1 : 0;
      if (MW != 0 && blocked > MW) begin
         blocked = MW;
         forced  = 1'b1;
      end
      exp_ack   = we ? blocked + 2 : blocked + 3;
      exp_stall = forced ? blocked + 2 : -1;
`ifdef VRAM_ARB_WRBUF_EN
      buffered = we;
      if (buffered) exp_ack = 1;
`endif

      cpu_req     = 1'b1;
      cpu_we      = we;
      cpu_address = addr;
      cpu_wdata   = wd;
      vid_req     = (busy > 0);
      vid_address = AW'($urandom);
      while (ack_cyc < 0 && cyc < 200) begin
         @(negedge clock);
         if (mem_wren) wren_cnt++;
         if (vid_stall && stall_cyc < 0) stall_cyc = cyc;
         if (cpu_ack) begin
            ack_cyc = cyc;
            rd      = cpu_rdata;
         end
         next_cycle();
         cyc++;
         vid_req     = (cyc < busy);
         vid_address = AW'($urandom);
         if (ack_cyc >= 0) cpu_req = 1'b0;
      end
      vid_req = 1'b0;
      cpu_req = 1'b0;

      check(we ? "wr_latency" : "rd_latency", ack_cyc, exp_ack);
      if (we) begin
         ref_mem[addr] = wd;
      end else begin
         check("rd_data", int'(rd), int'(ref_mem[addr]));
      end
      if (!buffered) begin
         check("wren_cycles", wren_cnt, we ? 1 : 0);
         check("stall_cycle", stall_cyc, exp_stall);
      end
      repeat (3) next_cycle();
   endtask

   // Display-only reads: data of the previous cycle's address appears one cycle later.
   task automatic vid_phase(input int n);
      logic [AW-1:0] prev;
      vid_req     = 1'b1;
      prev        = AW'($urandom);
      vid_address = prev;
      #1;
      check("idle_mux_addr", int'(mem_address), int'(prev));
      for (int i = 0; i < n; i++) begin
         next_cycle();
         check("vid_data", int'(vid_data), int'(ref_mem[prev]));
         check("vid_no_wren", int'(mem_wren), 0);
         prev        = AW'($urandom);
         vid_address = prev;
      end
      next_cycle();
      vid_req = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, checks=%0d", checks);
      $fatal(1);
   end

   initial begin
      int acks;
      int wrens;

      for (int i = 0; i < (1 << AW); i++) begin
         ram[i]     = 8'($urandom);
         ref_mem[i] = ram[i];
      end
      reset       = 1'b1;
      vid_req     = 1'b0;
      vid_address = '0;
      cpu_req     = 1'b0;
      cpu_we      = 1'b0;
      cpu_address = '0;
      cpu_wdata   = '0;
      #1;
      check("rst_cpu_ack", int'(cpu_ack), 0);
      check("rst_cpu_rdata", int'(cpu_rdata), 0);
      check("rst_vid_stall", int'(vid_stall), 0);
      check("rst_mem_wren", int'(mem_wren), 0);
      repeat (2) next_cycle();
      reset = 1'b0;
      next_cycle();

      // Free-bus write then read-back.
      do_txn(1'b1, AW'(12'h010), 8'h41, 0);
      do_txn(1'b0, AW'(12'h010), 8'h00, 0);
      // Display busy for 6 pending cycles, then a stuck display forcing a grant.
      do_txn(1'b0, AW'(12'h010), 8'h00, 7);
      do_txn(1'b1, AW'(12'h123), 8'hC3, 100);
      do_txn(1'b0, AW'(12'h123), 8'h00, 100);
      do_txn(1'b0, AW'(12'h010), 8'h00, MW + 1);
      do_txn(1'b0, AW'(12'h010), 8'h00, MW + 2);

      vid_phase(8);

      // Reset while pending: no ack may follow, even once the bus frees up.
      cpu_req     = 1'b1;
      cpu_we      = 1'b1;
      cpu_address = AW'(12'h020);
      cpu_wdata   = 8'hEE;
      vid_req     = 1'b1;
      repeat (5) next_cycle();
      reset = 1'b1;
      #1;
      check("ack_during_reset", int'(cpu_ack), 0);
      cpu_req = 1'b0;
      vid_req = 1'b0;
      next_cycle();
      reset = 1'b0;
      acks  = 0;
      wrens = 0;
      repeat (20) begin
         @(negedge clock);
         if (cpu_ack) acks++;
         if (mem_wren) wrens++;
      end
      check("ack_after_reset", acks, 0);
      check("wren_after_reset", wrens, 0);
      next_cycle();
      do_txn(1'b0, AW'(12'h020), 8'h00, 40);

`ifdef VRAM_ARB_WRBUF_EN
      begin
         int         cyc    = 0;
         int         first  = -1;
         int         second = -1;
         logic [7:0] rd     = 8'h00;
         cpu_req     = 1'b1;
         cpu_we      = 1'b1;
         cpu_address = AW'(12'h2A5);
         cpu_wdata   = 8'h5A;
         vid_req     = 1'b1;
         while (second < 0 && cyc < 100) begin
            @(negedge clock);
            if (cpu_ack) begin
               if (first < 0) begin
                  first = cyc;
               end else begin
                  second = cyc;
                  rd     = cpu_rdata;
               end
            end
            next_cycle();
            cyc++;
            vid_req = (cyc < 10);
            if (second >= 0) cpu_req = 1'b0;
            else if (first >= 0) cpu_we = 1'b0;
         end
         cpu_req = 1'b0;
         vid_req = 1'b0;
         ref_mem[12'h2A5] = 8'h5A;
         check("wrbuf_wr_ack", first, 1);
         check("wrbuf_rd_ack", second, 13);
         check("wrbuf_rd_data", int'(rd), 8'h5A);
         repeat (3) next_cycle();
      end
`endif

      for (int t = 0; t < 40; t++) begin
         int pick;
         int busy;
         pick = int'($urandom_range(0, 3));
         case (pick)
            0:       busy = 0;
            1:       busy = int'($urandom_range(1, 8));
            2:       busy = int'($urandom_range(14, 20));
            default: busy = int'($urandom_range(0, 3));
         endcase
         do_txn(1'($urandom), AW'($urandom_range(0, 31)), 8'($urandom), busy);
      end

      vid_phase(6);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
